// File: rtl/complex_mult_pkg.sv
// Shared constants and types for the pipelined complex multiplier.
// Holds the result width formula, op_data field offsets and the {re,im} result pair.
package complex_mult_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    // Guard bits cover the worst-case sum or difference of two full-width products.
    function automatic int res_width(input int dw);
        return 2 * dw + 2;
    endfunction

    localparam int RES_WIDTH_DEF = res_width(DATA_WIDTH_DEF);

    // Field index within op_data, in units of DATA_WIDTH: {a,b,c,d}
    localparam int OP_A_IDX = 3;
    localparam int OP_B_IDX = 2;
    localparam int OP_C_IDX = 1;
    localparam int OP_D_IDX = 0;

    typedef struct packed {
        logic signed [RES_WIDTH_DEF-1:0] re;
        logic signed [RES_WIDTH_DEF-1:0] im;
    } cplx_res_t;

endpackage

// File: rtl/sint_mult.sv
// Combinational DATA_WIDTH x DATA_WIDTH multiplier with a signed/unsigned select.
// Operands are extended to the full product width so one multiply serves both modes.
module sint_mult
    import complex_mult_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [DATA_WIDTH-1:0]   i_a,
    input  logic [DATA_WIDTH-1:0]   i_b,
    input  logic                    i_signed,
    output logic [2*DATA_WIDTH-1:0] o_prod
);

    logic [2*DATA_WIDTH-1:0] w_a_ext;
    logic [2*DATA_WIDTH-1:0] w_b_ext;

    // Modulo-2^(2W) product of extended operands is exact in both modes.
    assign w_a_ext = {{DATA_WIDTH{i_signed & i_a[DATA_WIDTH-1]}}, i_a};
    assign w_b_ext = {{DATA_WIDTH{i_signed & i_b[DATA_WIDTH-1]}}, i_b};
    assign o_prod  = w_a_ext * w_b_ext;

endmodule

// File: rtl/complex_nr_mult_pipe.sv
// Two-stage pipelined complex multiplier (a+bi)*(c+di) with valid/ready flow control.
// Optional macro COMPLEX_MULT_CONJ_EN adds op_conj to compute (a+bi)*(c-di) per operand.
module complex_nr_mult_pipe
    import complex_mult_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int RES_WIDTH  = res_width(DATA_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    sw_rst,
    input  logic                    op_val,
    output logic                    op_ready,
    input  logic [4*DATA_WIDTH-1:0] op_data,
    input  logic                    op_signed,
`ifdef COMPLEX_MULT_CONJ_EN
    input  logic                    op_conj,
`endif
    input  logic                    res_ready,
    output logic                    res_val,
    output logic [2*RES_WIDTH-1:0]  res_data
);

    localparam int PW = 2 * DATA_WIDTH;

    function automatic logic signed [RES_WIDTH-1:0] ext_prod(
        input logic [PW-1:0] p,
        input logic          sgn
    );
        logic msb;
        msb = sgn & p[PW-1];
        return $signed({{(RES_WIDTH-PW){msb}}, p});
    endfunction

    logic [DATA_WIDTH-1:0] w_a, w_b, w_c, w_d;
    logic [PW-1:0]         w_ac, w_bd, w_ad, w_bc;
    logic                  w_en1, w_en2, w_acc;

    logic [PW-1:0]         r_ac_p1, r_bd_p1, r_ad_p1, r_bc_p1;
    logic                  r_sgn_p1;
    logic                  r_vld_p1;
`ifdef COMPLEX_MULT_CONJ_EN
    logic                  r_conj_p1;
`endif

    logic signed [RES_WIDTH-1:0] w_ac_x, w_bd_x, w_ad_x, w_bc_x;
    logic signed [RES_WIDTH-1:0] w_re, w_im;
    logic signed [RES_WIDTH-1:0] r_re_p2, r_im_p2;
    logic                        r_vld_p2;

    assign w_a = op_data[OP_A_IDX*DATA_WIDTH +: DATA_WIDTH];
    assign w_b = op_data[OP_B_IDX*DATA_WIDTH +: DATA_WIDTH];
    assign w_c = op_data[OP_C_IDX*DATA_WIDTH +: DATA_WIDTH];
    assign w_d = op_data[OP_D_IDX*DATA_WIDTH +: DATA_WIDTH];

    assign w_en2    = ~r_vld_p2 | res_ready;
    assign w_en1    = ~r_vld_p1 | w_en2;
    assign op_ready = w_en1;
    assign w_acc    = op_val & w_en1;

    sint_mult #(.DATA_WIDTH(DATA_WIDTH)) u_mult_ac (
        .i_a(w_a), .i_b(w_c), .i_signed(op_signed), .o_prod(w_ac)
    );
    sint_mult #(.DATA_WIDTH(DATA_WIDTH)) u_mult_bd (
        .i_a(w_b), .i_b(w_d), .i_signed(op_signed), .o_prod(w_bd)
    );
    sint_mult #(.DATA_WIDTH(DATA_WIDTH)) u_mult_ad (
        .i_a(w_a), .i_b(w_d), .i_signed(op_signed), .o_prod(w_ad)
    );
    sint_mult #(.DATA_WIDTH(DATA_WIDTH)) u_mult_bc (
        .i_a(w_b), .i_b(w_c), .i_signed(op_signed), .o_prod(w_bc)
    );

    // Stage 1: four partial products, tagged with their operand mode
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vld_p1  <= 1'b0;
            r_sgn_p1  <= 1'b0;
            r_ac_p1   <= '0;
            r_bd_p1   <= '0;
            r_ad_p1   <= '0;
            r_bc_p1   <= '0;
`ifdef COMPLEX_MULT_CONJ_EN
            r_conj_p1 <= 1'b0;
`endif
        end else if (sw_rst) begin
            r_vld_p1  <= 1'b0;
            r_sgn_p1  <= 1'b0;
            r_ac_p1   <= '0;
            r_bd_p1   <= '0;
            r_ad_p1   <= '0;
            r_bc_p1   <= '0;
`ifdef COMPLEX_MULT_CONJ_EN
            r_conj_p1 <= 1'b0;
`endif
        end else begin
            if (w_en1) begin
                r_vld_p1 <= op_val;
            end
            if (w_acc) begin
                r_sgn_p1  <= op_signed;
                r_ac_p1   <= w_ac;
                r_bd_p1   <= w_bd;
                r_ad_p1   <= w_ad;
                r_bc_p1   <= w_bc;
`ifdef COMPLEX_MULT_CONJ_EN
                r_conj_p1 <= op_conj;
`endif
            end
        end
    end

    always_comb begin
        w_ac_x = ext_prod(r_ac_p1, r_sgn_p1);
        w_bd_x = ext_prod(r_bd_p1, r_sgn_p1);
        w_ad_x = ext_prod(r_ad_p1, r_sgn_p1);
        w_bc_x = ext_prod(r_bc_p1, r_sgn_p1);
`ifdef COMPLEX_MULT_CONJ_EN
        if (r_conj_p1) begin
            w_re = w_ac_x + w_bd_x;
            w_im = w_bc_x - w_ad_x;
        end else begin
            w_re = w_ac_x - w_bd_x;
            w_im = w_ad_x + w_bc_x;
        end
`else
        w_re = w_ac_x - w_bd_x;
        w_im = w_ad_x + w_bc_x;
`endif
    end

    // Stage 2: real/imaginary combine; holds while the consumer stalls
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vld_p2 <= 1'b0;
            r_re_p2  <= '0;
            r_im_p2  <= '0;
        end else if (sw_rst) begin
            r_vld_p2 <= 1'b0;
            r_re_p2  <= '0;
            r_im_p2  <= '0;
        end else begin
            if (w_en2) begin
                r_vld_p2 <= r_vld_p1;
            end
            if (w_en2 && r_vld_p1) begin
                r_re_p2 <= w_re;
                r_im_p2 <= w_im;
            end
        end
    end

    assign res_val  = r_vld_p2;
    assign res_data = {r_re_p2, r_im_p2};

endmodule

// File: doc/complex_nr_mult_pipe.md
COMPLEX_NR_MULT_PIPE -- requirements
Module: complex_nr_mult_pipe

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the width of each operand component.
REQ-002 The block SHALL have parameter RES_WIDTH, default 2*DATA_WIDTH+2, giving the width of each result component; this value is fixed and not overridden.
REQ-003 The block SHALL have these ports:
  - clk  in  1  single clock; all state updates on its rising edge.
  - rstn  in  1  reset; asynchronous, active-low.
  - sw_rst  in  1  software reset; synchronous, active-high.
  - op_val  in  1  operand valid.
  - op_ready  out  1  block accepts an operand this cycle.
  - op_data  in  4*DATA_WIDTH  operands {a,b,c,d}: a=[4W-1:3W], b=[3W-1:2W], c=[2W-1:W], d=[W-1:0]; computes (a+bi)*(c+di).
  - op_signed  in  1  1: operands are two's complement; 0: operands are unsigned. Sampled with the operand.
  - res_ready  in  1  consumer accepts a result.
  - res_val  out  1  result valid.
  - res_data  out  2*RES_WIDTH  {re,im}; each component is two's complement, RES_WIDTH bits.

Function
REQ-004 An operand transfer SHALL occur when op_val and op_ready are both 1 in a cycle; a result transfer SHALL occur when res_val and res_ready are both 1.
REQ-005 The datapath SHALL be a 2-stage pipeline: S1 registers the four products a*c, b*d, a*d and b*c with a valid bit v1; S2 registers re=a*c-b*d and im=a*d+b*c with a valid bit v2; res_val SHALL equal v2.
REQ-006 Latency SHALL be 2 cycles: an operand accepted at edge N produces res_val=1 after edge N+2 when no stall occurs.
REQ-007 Stall logic: en2 = ~v2 | res_ready; en1 = ~v1 | en2; op_ready = en1. op_ready SHALL depend combinationally on res_ready.
REQ-008 Throughput SHALL be one result per cycle while res_ready=1; there SHALL be no bubbles and no loss or duplication under any res_ready pattern.
REQ-009 While a stage is stalled, its data and valid bit SHALL hold; res_data SHALL remain stable while res_val=1 and res_ready=0.
REQ-010 Products SHALL be formed at 2*DATA_WIDTH bits, signed or unsigned per the operand's op_signed, then sign- or zero-extended to RES_WIDTH before the add/subtract; no overflow or truncation is possible.
REQ-011 op_signed SHALL be pipelined alongside its operand, so that mixed-mode back-to-back operands each compute correctly.
REQ-012 When a stage is not valid, it SHALL NOT update its data registers.

Reset
REQ-013 When rstn=0, asynchronously: v1=0, v2=0, all data registers=0; res_val=0, res_data=0, op_ready=1.
REQ-014 sw_rst=1 SHALL produce the same state at the next edge, overriding every other input; results in flight are discarded, and a transfer offered in that cycle is dropped.

Configuration
REQ-015 When macro COMPLEX_MULT_CONJ_EN is defined:
  - the block SHALL add input op_conj (1 bit), sampled and pipelined with the operand;
  - when op_conj=1, the block SHALL compute (a+bi)*(c-di): re=a*c+b*d, im=b*c-a*d.
REQ-016 When the macro is undefined, op_conj SHALL be absent and the behaviour SHALL be exactly as in REQ-005.

Structure
REQ-017 Package complex_mult_pkg SHALL hold:
  - DATA_WIDTH default;
  - the RES_WIDTH formula;
  - op_data field offset constants;
  - a typedef for the {re,im} result pair.
REQ-018 Sub-module sint_mult SHALL be instantiated 4 times: a parametrised DATA_WIDTH multiplier with a signed/unsigned select input and a 2*DATA_WIDTH output.

Verification (DATA_WIDTH=8, RES_WIDTH=18)
REQ-019 Unsigned, a=3 b=4 c=5 d=6 -> re=-9 (0x3FFF7), im=38 (0x00026), res_val 2 cycles after accept.
REQ-020 Signed, a=-128 b=-128 c=-128 d=127 -> re=32640, im=128.
REQ-021 Unsigned, all operands 255 -> re=0, im=130050.
REQ-022 res_ready=0 and 3 back-to-back operands -> 2 accepted, then op_ready=0; when res_ready is raised, the 3 results emerge in order and none are lost.
REQ-023 sw_rst pulse with both stages valid -> next cycle res_val=0, res_data=0, op_ready=1, and no stale result emerges afterwards.
REQ-024 With COMPLEX_MULT_CONJ_EN defined, op_conj=1 and unsigned a=3 b=4 c=5 d=6 -> re=39, im=2.
